// File: rtl/pipeline_step_ctrl_if.sv
// Handshake bundle between the debug unit / pipeline and the step controller.
// The controller takes the slave view; the debug unit and latches take the master view.
interface pipeline_step_ctrl_if #(
   parameter int BITS_CYCLES = 32
);
   // Debug requests and pipeline status flags
   logic                   run_req;
   logic                   step_req;
   logic                   stop_req;
   logic                   clear;
   logic                   halt_wb;
   logic                   branch_taken;
   logic                   jump_id;
   logic                   stall_hazard;

   // Latch / PC controls and debug readback
   logic                   step;
   logic                   pc_write;
   logic                   ifid_write;
   logic                   flush_ifid;
   logic                   flush_idex;
   logic                   flush_exmem;
   logic                   flush_all;
   logic                   halted;
   logic [1:0]             state;
   logic [BITS_CYCLES-1:0] cycle_count;

   modport master (
      output run_req, step_req, stop_req, clear, halt_wb,
             branch_taken, jump_id, stall_hazard,
      input  step, pc_write, ifid_write, flush_ifid, flush_idex,
             flush_exmem, flush_all, halted, state, cycle_count
   );

   modport slave (
      input  run_req, step_req, stop_req, clear, halt_wb,
             branch_taken, jump_id, stall_hazard,
      output step, pc_write, ifid_write, flush_ifid, flush_idex,
             flush_exmem, flush_all, halted, state, cycle_count
   );
endinterface

// File: rtl/pipeline_step_ctrl.sv
// Step/run/halt sequencer for the five-stage pipeline: global latch advance
// enable, per-latch flush and write controls, and a saturating cycle counter.
module pipeline_step_ctrl #(
   parameter int BITS_CYCLES = 32
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   pipeline_step_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [BITS_CYCLES-1:0] count_q;
   logic                   step_en;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      step_en = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.halt_wb) begin
               state_d = HALTED;
            end else if (bus.run_req) begin
               state_d = RUN;
            end else if (bus.step_req) begin
               state_d = STEP;
            end
         end
         RUN: begin
            // Halt at write-back suppresses the advance in the same cycle so
            // nothing younger than HALT retires.
            step_en = !bus.halt_wb;
            if (bus.halt_wb) begin
               state_d = HALTED;
            end else if (bus.stop_req) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            step_en = 1'b1;
            state_d = IDLE;
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (bus.clear) begin
         state_d = IDLE;
      end
   end

   // Counts advances since the last clear; sticks at all-ones instead of wrapping.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         count_q <= '0;
      end else if (bus.clear) begin
         count_q <= '0;
      end else if (step_en && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   // A taken branch outranks a load-use stall: the wrong-path instructions are
   // discarded anyway and the PC must take the branch target.
   assign bus.step        = step_en;
   assign bus.flush_ifid  = step_en & (bus.branch_taken | bus.jump_id);
   assign bus.flush_idex  = step_en & (bus.branch_taken | bus.stall_hazard);
   assign bus.flush_exmem = step_en & bus.branch_taken;
   assign bus.pc_write    = step_en & (bus.branch_taken | !bus.stall_hazard);
   assign bus.ifid_write  = step_en & (bus.branch_taken | !bus.stall_hazard);
   assign bus.flush_all   = bus.clear;
   assign bus.halted      = (state_q == HALTED);
   assign bus.state       = state_q;
   assign bus.cycle_count = count_q;

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed bench for pipeline_step_ctrl: a 32-bit counter instance for the
// sequencing scenarios and a 4-bit instance for counter saturation.
module tb_pipeline_step_ctrl;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   pipeline_step_ctrl_if #(.BITS_CYCLES(32)) a ();
   pipeline_step_ctrl_if #(.BITS_CYCLES(4))  b ();

   pipeline_step_ctrl #(.BITS_CYCLES(32)) dut_a (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (a.slave)
   );

   pipeline_step_ctrl #(.BITS_CYCLES(4)) dut_b (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a.run_req = 0; a.step_req = 0; a.stop_req = 0; a.clear = 0;
      a.halt_wb = 0; a.branch_taken = 0; a.jump_id = 0; a.stall_hazard = 0;
      b.run_req = 0; b.step_req = 0; b.stop_req = 0; b.clear = 0;
      b.halt_wb = 0; b.branch_taken = 0; b.jump_id = 0; b.stall_hazard = 0;
   endtask

   initial begin
      int run_steps;
      checks = 0;
      errors = 0;
      idle_inputs();
      rst_n = 1'b0;
      #12;
      check("reset_state", 32'(a.state), 0);
      check("reset_count", a.cycle_count, 0);
      check("reset_step", 32'(a.step), 0);
      check("reset_flush_all", 32'(a.flush_all), 0);
      check("reset_pc_write", 32'(a.pc_write), 0);
      check("reset_halted", 32'(a.halted), 0);
      rst_n = 1'b1;
      tick();
      check("idle_after_reset", 32'(a.state), 0);

      // Three single steps with two-cycle gaps
      for (int k = 0; k < 3; k++) begin
         a.step_req = 1;
         tick();
         a.step_req = 0;
         check($sformatf("step%0d_state", k), 32'(a.state), 2);
         check($sformatf("step%0d_step", k), 32'(a.step), 1);
         tick();
         check($sformatf("step%0d_back_idle", k), 32'(a.state), 0);
         check($sformatf("step%0d_step_low", k), 32'(a.step), 0);
         tick();
      end
      check("step_count", a.cycle_count, 3);

      // Clear from IDLE zeroes the counter
      a.clear = 1;
      #1;
      check("clear_flush_all", 32'(a.flush_all), 1);
      tick();
      a.clear = 0;
      check("clear_count", a.cycle_count, 0);

      // Run for ten advances, then HALT reaches write-back
      a.run_req = 1;
      tick();
      a.run_req = 0;
      check("run_state", 32'(a.state), 1);
      run_steps = 0;
      for (int i = 0; i < 10; i++) begin
         if (a.step) run_steps++;
         tick();
      end
      check("run_step_cycles", run_steps, 10);
      a.halt_wb = 1;
      #1;
      check("halt_cycle_step", 32'(a.step), 0);
      check("halt_cycle_pc_write", 32'(a.pc_write), 0);
      tick();
      a.halt_wb = 0;
      check("halted_state", 32'(a.state), 3);
      check("halted_flag", 32'(a.halted), 1);
      check("halted_count", a.cycle_count, 10);
      a.run_req = 1;
      tick();
      a.run_req = 0;
      check("halted_ignores_run", 32'(a.state), 3);

      // Clear out of HALTED
      a.clear = 1;
      #1;
      check("halted_clear_flush_all", 32'(a.flush_all), 1);
      tick();
      a.clear = 0;
      check("post_clear_state", 32'(a.state), 0);
      check("post_clear_count", a.cycle_count, 0);
      check("post_clear_halted", 32'(a.halted), 0);

      // Hazard gating in IDLE: no step, so no flushes
      a.branch_taken = 1;
      #1;
      check("idle_branch_no_flush", 32'(a.flush_exmem), 0);
      a.branch_taken = 0;

      // Hazard controls while running
      a.run_req = 1;
      tick();
      a.run_req = 0;
      a.stall_hazard = 1;
      #1;
      check("stall_pc_write", 32'(a.pc_write), 0);
      check("stall_ifid_write", 32'(a.ifid_write), 0);
      check("stall_flush_idex", 32'(a.flush_idex), 1);
      check("stall_flush_ifid", 32'(a.flush_ifid), 0);
      check("stall_flush_exmem", 32'(a.flush_exmem), 0);
      a.branch_taken = 1;
      #1;
      check("branch_stall_pc_write", 32'(a.pc_write), 1);
      check("branch_stall_ifid_write", 32'(a.ifid_write), 1);
      check("branch_flush_ifid", 32'(a.flush_ifid), 1);
      check("branch_flush_idex", 32'(a.flush_idex), 1);
      check("branch_flush_exmem", 32'(a.flush_exmem), 1);
      a.branch_taken = 0;
      a.stall_hazard = 0;
      a.jump_id = 1;
      #1;
      check("jump_flush_ifid", 32'(a.flush_ifid), 1);
      check("jump_flush_idex", 32'(a.flush_idex), 0);
      check("jump_pc_write", 32'(a.pc_write), 1);
      a.jump_id = 0;

      // Stop request: the stop cycle still advances, then IDLE
      a.stop_req = 1;
      #1;
      check("stop_cycle_step", 32'(a.step), 1);
      tick();
      a.stop_req = 0;
      check("stop_state", 32'(a.state), 0);
      check("stop_step_low", 32'(a.step), 0);

      // Run beats step when both arrive together
      a.run_req = 1;
      a.step_req = 1;
      tick();
      a.run_req = 0;
      a.step_req = 0;
      check("run_beats_step_state", 32'(a.state), 1);
      tick();
      check("run_beats_step_continuous", 32'(a.step), 1);

      // Clear with a request in RUN: this cycle still steps, counter zeroed
      a.clear = 1;
      a.run_req = 1;
      #1;
      check("clear_in_run_step", 32'(a.step), 1);
      tick();
      a.clear = 0;
      a.run_req = 0;
      check("clear_in_run_state", 32'(a.state), 0);
      check("clear_in_run_count", a.cycle_count, 0);

      // Held step request: ignored in STEP, re-sampled in IDLE
      a.step_req = 1;
      tick();
      check("held_step_first", 32'(a.state), 2);
      tick();
      check("held_step_ignored", 32'(a.state), 0);
      tick();
      a.step_req = 0;
      check("held_step_second", 32'(a.state), 2);
      tick();
      check("held_step_count", a.cycle_count, 2);

      // Halt flag in IDLE goes straight to HALTED
      a.halt_wb = 1;
      tick();
      a.halt_wb = 0;
      check("idle_halt_state", 32'(a.state), 3);

      // 4-bit counter saturates at 15
      b.run_req = 1;
      tick();
      b.run_req = 0;
      for (int i = 0; i < 20; i++) tick();
      check("sat_count", 32'(b.cycle_count), 15);
      check("sat_still_running", 32'(b.step), 1);

      // Asynchronous reset mid-run
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_step", 32'(b.step), 0);
      check("async_reset_state", 32'(b.state), 0);
      check("async_reset_count", 32'(b.cycle_count), 0);
      check("async_reset_pc_write", 32'(b.pc_write), 0);
      check("async_reset_halted_a", 32'(a.halted), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
